// File: rtl/qspi_pkg.sv
// Shared types and constants for the quad-I/O flash read sequencer.
package qspi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        MODE,
        DUMMY,
        DATA,
        DESEL
    } state_t;

    localparam logic [7:0] CMD_QUAD_IO_READ = 8'hEB;

    localparam logic [3:0] CMD_SLOTS    = 4'd8;
    localparam logic [3:0] ADDR_SLOTS   = 4'd6;
    localparam logic [3:0] MODE_SLOTS   = 4'd2;
    localparam logic [3:0] DATA_SLOTS   = 4'd8;
    localparam logic [3:0] DESEL_CYCLES = 4'd2;

    // {douten, dout} for a given phase and slot; WP#/HOLD# stay high in CMD
    function automatic logic [4:0] io_drive(
        input state_t      st,
        input logic [3:0]  slot,
        input logic [21:0] addr,
        input logic [7:0]  mode
    );
        logic [23:0] a;
        logic [2:0]  bi;
        a  = {addr, 2'b00} << {slot[2:0], 2'b00};
        bi = 3'd7 - slot[2:0];
        unique case (st)
            CMD:     io_drive = {1'b1, 3'b110, CMD_QUAD_IO_READ[bi]};
            ADDR:    io_drive = {1'b1, a[23:20]};
            MODE:    io_drive = {1'b1, slot[0] ? mode[3:0] : mode[7:4]};
            default: io_drive = 5'b0;
        endcase
    endfunction

endpackage

// File: rtl/qspi_flash_reader.sv
// Quad I/O Fast Read (0xEB) sequencer: one 32-bit little-endian word per request.
module qspi_flash_reader
    import qspi_pkg::*;
#(
    parameter int         DUMMY_CYCLES = 4,
    parameter logic [7:0] MODE_BYTE    = 8'h00
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        req_valid,
    input  logic [23:0] req_addr,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        fr_sck,
    output logic        fr_ce_n,
    output logic [3:0]  fr_dout,
    output logic        fr_douten,
    input  logic [3:0]  fr_din
);

    state_t      state;
    state_t      nstate;
    logic [3:0]  slot;
    logic [3:0]  nslot;
    logic [3:0]  plen;
    logic        last;
    logic        half;
    logic [21:0] addr;
    logic [31:0] rx;
    logic [31:0] rx_next;
    logic [4:0]  drv;
    logic [4:0]  start_drv;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = ^req_addr[1:0];

    always_comb begin
        unique case (state)
            CMD:     plen = CMD_SLOTS;
            ADDR:    plen = ADDR_SLOTS;
            MODE:    plen = MODE_SLOTS;
            DUMMY:   plen = 4'(DUMMY_CYCLES);
            DATA:    plen = DATA_SLOTS;
            default: plen = DESEL_CYCLES;
        endcase
        last   = (slot == plen - 4'd1);
        nstate = state;
        nslot  = slot + 4'd1;
        if (last) begin
            nslot = 4'd0;
            unique case (state)
                CMD:     nstate = ADDR;
                ADDR:    nstate = MODE;
                MODE:    nstate = DUMMY;
                DUMMY:   nstate = DATA;
                DATA:    nstate = DESEL;
                default: nstate = IDLE;
            endcase
        end
        // nibble k lands in byte k/2, high nibble first within each byte
        rx_next = rx;
        rx_next[{slot[2:1], ~slot[0], 2'b00} +: 4] = fr_din;
        drv       = io_drive(nstate, nslot, addr, MODE_BYTE);
        start_drv = io_drive(CMD, 4'd0, req_addr[23:2], MODE_BYTE);
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state      <= IDLE;
            slot       <= 4'd0;
            half       <= 1'b0;
            addr       <= 22'd0;
            rx         <= 32'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_data  <= 32'd0;
            fr_sck     <= 1'b0;
            fr_ce_n    <= 1'b1;
            fr_dout    <= 4'd0;
            fr_douten  <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        state     <= CMD;
                        addr      <= req_addr[23:2];
                        slot      <= 4'd0;
                        half      <= 1'b0;
                        req_ready <= 1'b0;
                        fr_ce_n   <= 1'b0;
                        fr_sck    <= 1'b0;
                        {fr_douten, fr_dout} <= start_drv;
                    end
                end
                DESEL: begin
                    slot <= nslot;
                    if (last) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    if (!half) begin
                        half   <= 1'b1;
                        fr_sck <= 1'b1;
                    end else begin
                        // end of high half: sample IO and advance one slot
                        half   <= 1'b0;
                        fr_sck <= 1'b0;
                        slot   <= nslot;
                        state  <= nstate;
                        {fr_douten, fr_dout} <= drv;
                        if (state == DATA) begin
                            rx <= rx_next;
                            if (last) begin
                                resp_valid <= 1'b1;
                                resp_data  <= rx_next;
                                fr_ce_n    <= 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qspi_flash_reader.sv
// Self-checking bench: two readers (4 and 8 dummy slots) against a behavioural flash model.
module tb_qspi_flash_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid [2];
    logic [23:0] req_addr  [2];
    wire         req_ready [2];
    wire         resp_valid[2];
    wire  [31:0] resp_data [2];
    wire         sck       [2];
    wire         ce_n      [2];
    wire  [3:0]  dout      [2];
    wire         douten    [2];

    wire  [7:0]  obs_cmd  [2];
    wire  [23:0] obs_addr [2];
    wire  [7:0]  obs_mode [2];
    wire  [7:0]  obs_slots[2];
    wire  [7:0]  obs_zero [2];
    wire         obs_bad  [2];

    int checks = 0;
    int errors = 0;
    int resp_cnt[2] = '{0, 0};

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        if (a >= 24'h000100 && a <= 24'h000103)
            return 8'h11 * (8'(a[1:0]) + 8'd1);
        return (a[7:0] * 8'd29) ^ a[15:8] ^ {a[19:16], a[23:20]} ^ 8'hA5;
    endfunction

    function automatic logic [31:0] exp_word(input logic [23:0] a);
        logic [23:0] b;
        b = {a[23:2], 2'b00};
        return {mem_byte(b + 24'd3), mem_byte(b + 24'd2),
                mem_byte(b + 24'd1), mem_byte(b)};
    endfunction

    for (genvar i = 0; i < 2; i++) begin : g
        localparam int D = (i == 0) ? 4 : 8;
        logic [3:0]  din = 4'd0;
        int          slot = 0;
        int          zero = 0;
        logic [7:0]  cmd = 8'd0;
        logic [23:0] wa = 24'd0;
        logic [7:0]  mode = 8'd0;
        bit          bad = 1'b0;

        qspi_flash_reader #(.DUMMY_CYCLES(D), .MODE_BYTE(8'h00)) dut (
            .HCLK      (clk),
            .HRESETn   (rst_n),
            .req_valid (req_valid[i]),
            .req_addr  (req_addr[i]),
            .req_ready (req_ready[i]),
            .resp_valid(resp_valid[i]),
            .resp_data (resp_data[i]),
            .fr_sck    (sck[i]),
            .fr_ce_n   (ce_n[i]),
            .fr_dout   (dout[i]),
            .fr_douten (douten[i]),
            .fr_din    (din)
        );

        // flash: decode the transaction by SCK rising-edge count within CE low
        always @(posedge sck[i] or negedge ce_n[i]) begin
            if (sck[i] !== 1'b1) begin
                slot = 0; zero = 0; cmd = 8'd0; wa = 24'd0;
                mode = 8'd0; bad = 1'b0; din = 4'd0;
            end else begin
                if (douten[i] !== 1'b1) zero++;
                if (slot < 8) begin
                    cmd = {cmd[6:0], dout[i][0]};
                    if (dout[i][3:1] !== 3'b110 || douten[i] !== 1'b1) bad = 1'b1;
                end else if (slot < 14) begin
                    wa = {wa[19:0], dout[i]};
                    if (douten[i] !== 1'b1) bad = 1'b1;
                end else if (slot < 16) begin
                    mode = {mode[3:0], dout[i]};
                    if (douten[i] !== 1'b1) bad = 1'b1;
                end else if (slot < 16 + D) begin
                    if (dout[i] !== 4'd0 || douten[i] !== 1'b0) bad = 1'b1;
                end else begin
                    int k;
                    logic [7:0] b;
                    k = slot - 16 - D;
                    b = mem_byte(wa + 24'(k / 2));
                    din = (k % 2 == 0) ? b[7:4] : b[3:0];
                end
                slot++;
            end
        end

        assign obs_cmd[i]   = cmd;
        assign obs_addr[i]  = wa;
        assign obs_mode[i]  = mode;
        assign obs_slots[i] = 8'(slot);
        assign obs_zero[i]  = 8'(zero);
        assign obs_bad[i]   = bad;
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++)
            if (resp_valid[k] === 1'b1) resp_cnt[k]++;
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic wait_accept(input int i, input logic [23:0] a, output bit ok);
        int n;
        @(negedge clk);
        req_valid[i] = 1'b1;
        req_addr[i]  = a;
        n = 0;
        while (req_ready[i] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 200);
        chk("accept", 32'(ok), 32'd1);
        if (ok) @(posedge clk);
    endtask

    // counts cycles from the accepting edge to resp_valid
    task automatic wait_resp(input int i, output int lat, output bit ready_low);
        lat = 1;
        ready_low = 1'b1;
        while (resp_valid[i] !== 1'b1 && lat < 200) begin
            if (req_ready[i] !== 1'b0) ready_low = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_read(input int i, input logic [23:0] a, input bit alt);
        int  d, lat, n;
        bit  ok, rl;
        d = (i == 0) ? 4 : 8;
        wait_accept(i, a, ok);
        if (!ok) begin
            req_valid[i] = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid[i] = 1'b0;
        req_addr[i]  = alt ? 24'hFFFFFC : 24'($urandom);
        wait_resp(i, lat, rl);
        chk("latency",    32'(lat), 32'(2 * (24 + d) + 1));
        chk("ready_low",  32'(rl), 32'd1);
        chk("data",       resp_data[i], exp_word(a));
        chk("cmd",        32'(obs_cmd[i]), 32'hEB);
        chk("addr",       32'(obs_addr[i]), 32'({a[23:2], 2'b00}));
        chk("mode",       32'(obs_mode[i]), 32'h00);
        chk("slots",      32'(obs_slots[i]), 32'(24 + d));
        chk("undriven",   32'(obs_zero[i]), 32'(d + 8));
        chk("drive",      32'(obs_bad[i]), 32'd0);
        @(negedge clk);
        chk("pulse",      32'(resp_valid[i]), 32'd0);
        chk("hold",       resp_data[i], exp_word(a));
        n = 0;
        while (req_ready[i] !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("ready_ret",  32'(n), 32'd1);
    endtask

    initial begin
        int  lat, hi, r0;
        bit  ok, rl;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0;
            req_addr[k]  = 24'd0;
        end
        repeat (3) @(negedge clk);
        chk("rst_ce_n",   32'(ce_n[0]), 32'd1);
        chk("rst_sck",    32'(sck[0]), 32'd0);
        chk("rst_douten", 32'(douten[0]), 32'd0);
        chk("rst_dout",   32'(dout[0]), 32'd0);
        chk("rst_ready",  32'(req_ready[0]), 32'd1);
        chk("rst_rvalid", 32'(resp_valid[0]), 32'd0);
        chk("rst_rdata",  resp_data[0], 32'd0);
        rst_n = 1'b1;

        do_read(0, 24'h000100, 1'b0);
        chk("word_0x100", resp_data[0], 32'h44332211);
        do_read(0, 24'h000103, 1'b0);
        chk("word_0x103", resp_data[0], 32'h44332211);
        do_read(0, 24'h000240, 1'b1);

        for (int t = 0; t < 5; t++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_read(0, 24'($urandom), 1'b0);
        end

        // back-to-back with req_valid held high
        r0 = resp_cnt[0];
        wait_accept(0, 24'h000000, ok);
        @(negedge clk);
        req_addr[0] = 24'h000004;
        wait_resp(0, lat, rl);
        chk("b2b_lat0",   32'(lat), 32'd57);
        chk("b2b_rdy0",   32'(rl), 32'd1);
        chk("b2b_data0",  resp_data[0], exp_word(24'h0));
        hi = 0;
        while (ce_n[0] === 1'b1 && hi < 50) begin
            hi++;
            @(negedge clk);
        end
        chk("b2b_ce_hi",  32'(hi >= 3 && hi < 50), 32'd1);
        req_valid[0] = 1'b0;
        wait_resp(0, lat, rl);
        chk("b2b_lat1",   32'(lat), 32'd57);
        chk("b2b_rdy1",   32'(rl), 32'd1);
        chk("b2b_data1",  resp_data[0], exp_word(24'h4));
        chk("b2b_addr1",  32'(obs_addr[0]), 32'h4);
        @(negedge clk);
        chk("b2b_pulses", 32'(resp_cnt[0] - r0), 32'd2);
        repeat (3) @(negedge clk);

        for (int t = 0; t < 2; t++) do_read(1, 24'($urandom), 1'b0);
        do_read(1, 24'h000100, 1'b0);

        // reset asserted mid-DATA
        wait_accept(0, 24'($urandom), ok);
        repeat (46) @(negedge clk);
        req_valid[0] = 1'b0;
        r0 = resp_cnt[0];
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_ce_n",   32'(ce_n[0]), 32'd1);
        chk("mid_douten", 32'(douten[0]), 32'd0);
        chk("mid_sck",    32'(sck[0]), 32'd0);
        chk("mid_ready",  32'(req_ready[0]), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        chk("mid_noresp", 32'(resp_cnt[0] - r0), 32'd0);

        do_read(0, 24'($urandom), 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qspi_flash_reader.md
Name: qspi_flash_reader

Overview:
- Read sequencer directly upstream of the flash writer mux; it produces the fr_* side of that mux (fr_sck, fr_ce_n, fr_dout, fr_douten) and consumes fr_din.
- Converts a single-word read request into a Quad I/O Fast Read (0xEB) transaction and returns one 32-bit little-endian word.
- SCK runs at HCLK/2. While the writer's bit-bang override is active, this block is simply ignored; it needs no knowledge of it.

Parameters:
- DUMMY_CYCLES, 4, number of SCK cycles with IO released between the mode byte and the data (range 1..15).
- MODE_BYTE, 8'h00, continuous-read mode byte sent after the address; 8'h00 disables continuous mode, so every request carries the command.

Ports:
- HCLK  in  1  system clock
- HRESETn  in  1  reset, synchronous and active-low
- req_valid  in  1  read request
- req_addr  in  24  byte address; bits [1:0] are ignored and forced to 0 on the wire
- req_ready  out  1  high only in IDLE
- resp_valid  out  1  one-cycle pulse; resp_data is valid in that cycle
- resp_data  out  32  read word; held until the next resp_valid
- fr_sck  out  1  flash clock, registered
- fr_ce_n  out  1  flash chip select, active-low, registered
- fr_dout  out  4  IO[3:0] drive value, registered
- fr_douten  out  1  1 = reader drives IO, registered
- fr_din  in  4  IO[3:0] sampled from the flash

Behaviour:
- Reset values (synchronous, HRESETn==0 at a clock edge):
  - state IDLE, fr_ce_n=1, fr_sck=0, fr_douten=0, fr_dout=4'b0000
  - req_ready=1, resp_valid=0, resp_data=0
- Reset mid-transfer: the next edge forces the reset values; CE_n rises immediately and no resp_valid is produced.
- Handshake:
  - A request is accepted on the edge where req_valid & req_ready; the address is captured at that edge.
  - req_valid and req_addr are don't-care after acceptance. No backpressure on the response.
- Slot timing: each SCK slot is 2 HCLK cycles.
  - Low half: fr_sck=0, fr_dout updated.
  - High half: fr_sck=1.
  - The flash samples on the rising edge.
  - The reader samples fr_din at the HCLK edge that ends the high half.
- FSM, entered from IDLE on the accepting edge; fr_ce_n=0 from the first CMD cycle through the end of DATA:
  - CMD (8 slots): 0xEB MSB-first on dout[0]; dout[3:2]=2'b11 (WP#/HOLD# high); dout[1]=0; douten=1.
  - ADDR (6 slots): {addr[23:2],2'b00} as nibbles, MSB nibble first; douten=1.
  - MODE (2 slots): MODE_BYTE, high nibble first; douten=1.
  - DUMMY (DUMMY_CYCLES slots): douten=0, dout=0.
  - DATA (8 slots): douten=0. Nibble k (k=0..7) is captured into byte k/2; even k fills bits [7:4] of that byte, odd k fills bits [3:0]. Byte 0 maps to resp_data[7:0].
  - DESEL (2 cycles): fr_ce_n=1, fr_sck=0. resp_valid=1 and resp_data is updated in the first DESEL cycle. Then return to IDLE.
- Latency: resp_valid rises 2*(24+DUMMY_CYCLES)+1 cycles after the accepting edge (57 with default). req_ready returns 2 cycles after that.
- Back-to-back: CE_n high time is ≥ 3 HCLK (2 DESEL cycles + 1 IDLE cycle) before the next CMD.
- Counters: the slot counter is 4 bits; the phase length comparison uses that same 4-bit width.

Decomposition:
- Package qspi_pkg holds:
  - the state enum (IDLE, CMD, ADDR, MODE, DUMMY, DATA, DESEL)
  - CMD_QUAD_IO_READ=8'hEB
  - phase lengths CMD_SLOTS=8, ADDR_SLOTS=6, MODE_SLOTS=2, DATA_SLOTS=8, DESEL_CYCLES=2
- Single module; no sub-module is warranted. The half-cycle toggle, slot counter and shift registers are all small.

Test Plan:
- Reset: hold HRESETn=0 for 3 cycles mid-DATA -> next edge fr_ce_n=1, fr_douten=0, fr_sck=0, req_ready=1, and no resp_valid follows.
- Single read: flash model holds bytes 0x11,0x22,0x33,0x44 at 0x000100; request 0x000100 -> 0xEB seen on IO0, address nibbles 0,0,0,1,0,0, mode 0x00; resp_data=32'h44332211 exactly 57 cycles after acceptance.
- Address alignment: req_addr=0x000103 -> address 0x000100 seen on the wire, same data as above.
- Back-to-back: req_valid held high with addresses 0x0 then 0x4 -> two transactions; CE_n high ≥3 HCLK between them; req_ready low throughout each transfer; two resp_valid pulses.
- Dummy parameter: DUMMY_CYCLES=8 -> 8 slots with douten=0 before DATA; latency 65 cycles; data is still correct.
- Request changes after acceptance: req_addr changes to 0xFFFFFC the cycle after acceptance -> the wire still carries the captured address and the response matches it.
